// File: rtl/inc_cnt8.sv
// ---------------------------------------------------------------------------
// Module  : inc_cnt8
// Brief   : Loadable up-counter with terminal limit, wrap/saturate modes,
//           registered carry-out and sticky overflow flag.
// Revision: 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module inc_cnt8 #(
  parameter int unsigned      WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  input  logic             sat_mode,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             cout,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] c_all_ones = '1;
  localparam logic [WIDTH-1:0] c_zero     = '0;

  logic [WIDTH-1:0] r_count;
  logic             r_tc;
  logic             r_cout;
  logic             r_ovf;

  logic [WIDTH:0]   w_sum;
  logic             w_at_limit;
  logic             w_at_max;
  logic             w_inc;
  logic [WIDTH-1:0] w_count_nxt;
  logic             w_tc_nxt;
  logic             w_cout_nxt;
  logic             w_ovf_nxt;

  assign w_sum      = {1'b0, r_count} + {{WIDTH{1'b0}}, 1'b1};
  assign w_at_limit = (r_count == limit);
  assign w_at_max   = (r_count == c_all_ones);
  assign w_inc      = en && !load;

  always_comb begin
    w_count_nxt = r_count;
    w_tc_nxt    = 1'b0;
    w_cout_nxt  = 1'b0;
    if (load) begin
      w_count_nxt = load_val;
    end else if (en) begin
      // Carry reflects the attempted increment, independent of wrap/saturate.
      w_cout_nxt = w_sum[WIDTH];
      if (w_at_limit) begin
        w_tc_nxt    = 1'b1;
        w_count_nxt = sat_mode ? r_count : c_zero;
      end else if (w_at_max) begin
        // Above-limit after a load: stop at the top or roll over, no tc.
        w_count_nxt = sat_mode ? r_count : c_zero;
      end else begin
        w_count_nxt = w_sum[WIDTH-1:0];
      end
    end
  end

  // Set has priority over clear so a coincident overflow is never lost.
  always_comb begin
    w_ovf_nxt = r_ovf;
    if (w_inc && w_cout_nxt) begin
      w_ovf_nxt = 1'b1;
    end else if (clr_ovf) begin
      w_ovf_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= RST_VAL;
      r_tc    <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_tc    <= w_tc_nxt;
      r_cout  <= w_cout_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  assign count = r_count;
  assign tc    = r_tc;
  assign cout  = r_cout;
  assign ovf   = r_ovf;

endmodule

`default_nettype wire
